// File: rtl/seg7_char_decoder_if.sv
// Character output channel of the segment decoder: decoded value plus flags.
// Producer holds char_valid and data stable until char_valid & char_ready.
// Consumer drives char_ready; the producer never waits on it to accept new glyphs.
interface seg7_char_decoder_if;
  logic       char_valid;
  logic       char_ready;
  logic [3:0] char_value;
  logic       char_blank;
  logic       char_err;

  modport master (
    output char_valid,
    output char_value,
    output char_blank,
    output char_err,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_value,
    input  char_blank,
    input  char_err,
    output char_ready
  );
endinterface

// File: rtl/seg7_char_decoder.sv
// Samples a 7-segment bus, debounces it and decodes a stable glyph to a hex char.
// Latency: char_valid rises STABLE_CYCLES edges after the edge that sees a new pattern.
// Backpressure: none upstream; an unread char is overwritten and overflow is set.
module seg7_char_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [6:0]                 seg_in,
  seg7_char_decoder_if.master        bus,
  output logic                       overflow
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

  typedef enum logic {WAIT, HELD} state_t;

  logic [6:0] seg_fix;
  logic [6:0] seg_q;
  logic [7:0] run;
  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic [3:0] dec_value;
  logic       dec_blank;
  logic       dec_err;

  // Normalise polarity so everything downstream sees lit segments as 1.
  assign seg_fix = SEG_ACTIVE_LOW ? (seg_in ^ 7'h7F) : seg_in;

  // Sample register and saturating count of consecutive identical samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= 7'h00;
      run   <= 8'd0;
    end else begin
      seg_q <= seg_fix;
      if (seg_fix != seg_q) begin
        run <= 8'd1;
      end else if (run < RUN_MAX) begin
        run <= run + 8'd1;
      end
    end
  end

  // Map the held active-high pattern to a hex value; blank and illegal read as 0.
  always_comb begin
    dec_value = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_q)
      7'h3F:   dec_value = 4'h0;
      7'h06:   dec_value = 4'h1;
      7'h5B:   dec_value = 4'h2;
      7'h4F:   dec_value = 4'h3;
      7'h66:   dec_value = 4'h4;
      7'h6D:   dec_value = 4'h5;
      7'h7D:   dec_value = 4'h6;
      7'h07:   dec_value = 4'h7;
      7'h7F:   dec_value = 4'h8;
      7'h6F:   dec_value = 4'h9;
      7'h77:   dec_value = 4'hA;
      7'h7C:   dec_value = 4'hB;
      7'h39:   dec_value = 4'hC;
      7'h5E:   dec_value = 4'hD;
      7'h79:   dec_value = 4'hE;
      7'h71:   dec_value = 4'hF;
      7'h00:   dec_blank = 1'b1;
      default: dec_err   = 1'b1;
    endcase
  end

  // Acceptance state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // One accept per stable pattern; a fresh pattern (run back to 1) re-arms.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      WAIT: begin
        if (run == RUN_MAX) begin
          accept    = 1'b1;
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (run == 8'd1) begin
          state_nxt = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  // Output holding register with handshake; newest char always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.char_valid <= 1'b0;
      bus.char_value <= 4'h0;
      bus.char_blank <= 1'b0;
      bus.char_err   <= 1'b0;
      overflow       <= 1'b0;
    end else if (accept) begin
      bus.char_valid <= 1'b1;
      bus.char_value <= dec_value;
      bus.char_blank <= dec_blank;
      bus.char_err   <= dec_err;
      if (bus.char_valid && !bus.char_ready) begin
        overflow <= 1'b1;
      end
    end else if (bus.char_valid && bus.char_ready) begin
      bus.char_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_char_decoder.sv
// Bench for seg7_char_decoder: one active-high and one active-low instance fed the
// same logical pattern, checked every cycle against a streak/pending model plus
// directed scenario checks.
module tb_seg7_char_decoder;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_a = 7'h00;
  logic [6:0] seg_b = 7'h7F;
  logic       ovf_a;
  logic       ovf_b;

  always #5 clk = ~clk;

  seg7_char_decoder_if if_a ();
  seg7_char_decoder_if if_b ();

  seg7_char_decoder #(.STABLE_CYCLES(N), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .seg_in   (seg_a),
    .bus      (if_a),
    .overflow (ovf_a)
  );

  seg7_char_decoder #(.STABLE_CYCLES(N), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .seg_in   (seg_b),
    .bus      (if_b),
    .overflow (ovf_b)
  );

  // Glyph list in hex-digit order; decode is a linear search of this table.
  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int vectors = 0;
  int miscompares = 0;
  int valid_cnt = 0;

  // Model state: length of the current run of identical samples, whether that run
  // already produced a char, and the consumer-visible pending char.
  int         streak = 0;
  bit         emitted = 1'b0;
  logic [6:0] last = 7'h00;
  bit         pend = 1'b0;
  logic [3:0] m_val = 4'h0;
  bit         m_blank = 1'b0;
  bit         m_err = 1'b0;
  bit         m_ovf = 1'b0;

  function automatic logic [5:0] glyph_decode(input logic [6:0] p);
    if (p == 7'h00) return {1'b1, 1'b0, 4'h0};
    for (int i = 0; i < 16; i++) begin
      if (glyphs[i] == p) return {1'b0, 1'b0, 4'(i)};
    end
    return {1'b0, 1'b1, 4'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [6:0] seg, input logic rdy, input logic rst);
    bit         acc;
    logic [7:0] exp_v;
    logic [7:0] got_a;
    logic [7:0] got_b;
    @(negedge clk);
    seg_a           = seg;
    seg_b           = seg ^ 7'h7F;
    if_a.char_ready = rdy;
    if_b.char_ready = rdy;
    reset           = rst;
    @(posedge clk);
    if (rst) begin
      streak = 0; emitted = 1'b0; last = 7'h00;
      pend = 1'b0; m_val = 4'h0; m_blank = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    end else begin
      acc = (streak >= N) && !emitted;
      if (acc) begin
        if (pend && !rdy) m_ovf = 1'b1;
        pend = 1'b1;
        {m_blank, m_err, m_val} = glyph_decode(last);
      end else if (pend && rdy) begin
        pend = 1'b0;
      end
      if (streak > 0 && seg == last) begin
        if (streak < N) streak++;
        if (acc) emitted = 1'b1;
      end else begin
        streak  = 1;
        emitted = 1'b0;
      end
      last = seg;
    end
    #1;
    exp_v = {pend, m_val, m_blank, m_err, m_ovf};
    got_a = {if_a.char_valid, if_a.char_value, if_a.char_blank, if_a.char_err, ovf_a};
    got_b = {if_b.char_valid, if_b.char_value, if_b.char_blank, if_b.char_err, ovf_b};
    if (if_a.char_valid) valid_cnt++;
    chk({tag, "_a"}, 32'(got_a), 32'(exp_v));
    chk({tag, "_b"}, 32'(got_b), 32'(exp_v));
  endtask

  initial begin
    logic [6:0] rseg;
    int         kind;
    int         hold;

    if_a.char_ready = 1'b1;
    if_b.char_ready = 1'b1;

    // Reset state.
    step("rst", 7'h3F, 1'b1, 1'b1);
    step("rst", 7'h3F, 1'b1, 1'b1);
    chk("reset_outputs", 32'({if_a.char_valid, if_a.char_value, if_a.char_blank, if_a.char_err, ovf_a}), 32'h0);

    // 3F held: exactly one char, on the 5th edge after the change.
    for (int i = 0; i < 4; i++) step("hold3f", 7'h3F, 1'b1, 1'b0);
    chk("hold3f_not_yet", 32'(if_a.char_valid), 32'd0);
    valid_cnt = 0;
    step("hold3f", 7'h3F, 1'b1, 1'b0);
    chk("hold3f_valid", 32'(if_a.char_valid), 32'd1);
    chk("hold3f_value", 32'(if_a.char_value), 32'h0);
    for (int i = 0; i < 100; i++) step("hold3f_long", 7'h3F, 1'b1, 1'b0);
    chk("hold3f_once", 32'(valid_cnt), 32'd1);

    // Short 5B glitch is filtered; the return to 3F re-arms and emits again.
    valid_cnt = 0;
    for (int i = 0; i < 3; i++) step("glitch5b", 7'h5B, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("back3f", 7'h3F, 1'b1, 1'b0);
    chk("glitch_count", 32'(valid_cnt), 32'd1);
    chk("back3f_value", 32'({if_a.char_valid, if_a.char_value}), 32'h10);

    // Illegal glyph and blank.
    for (int i = 0; i < 5; i++) step("err0f", 7'h0F, 1'b1, 1'b0);
    chk("err0f_flags", 32'({if_a.char_valid, if_a.char_err, if_a.char_blank, if_a.char_value}), 32'h60);
    for (int i = 0; i < 5; i++) step("blank", 7'h00, 1'b1, 1'b0);
    chk("blank_flags", 32'({if_a.char_valid, if_a.char_err, if_a.char_blank, if_a.char_value}), 32'h50);

    // Backpressure: 66 then 7D while unread -> newest kept, overflow sticky.
    for (int i = 0; i < 6; i++) step("bp66", 7'h66, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("bp7d", 7'h7D, 1'b0, 1'b0);
    chk("bp_value", 32'({if_a.char_valid, if_a.char_value, ovf_a}), 32'h2D);
    step("bp_drain", 7'h7D, 1'b1, 1'b0);
    chk("bp_drained", 32'({if_a.char_valid, ovf_a}), 32'h1);

    // Active-low instance: 0E on its pins is the F glyph.
    for (int i = 0; i < 5; i++) step("lowF", 7'h71, 1'b1, 1'b0);
    chk("lowF_input", 32'(seg_b), 32'h0E);
    chk("lowF_value", 32'({if_b.char_valid, if_b.char_value}), 32'h1F);

    // Reset part-way through filtering 06.
    for (int i = 0; i < 3; i++) step("pre06", 7'h06, 1'b1, 1'b0);
    step("mid_rst", 7'h06, 1'b1, 1'b1);
    chk("mid_rst_out", 32'({if_a.char_valid, if_a.char_value, ovf_a}), 32'h0);
    valid_cnt = 0;
    for (int i = 0; i < 4; i++) step("post06", 7'h06, 1'b1, 1'b0);
    chk("post06_none", 32'(valid_cnt), 32'd0);
    step("post06", 7'h06, 1'b1, 1'b0);
    chk("post06_value", 32'({if_a.char_valid, if_a.char_value}), 32'h11);

    // Randomised patterns, hold lengths, backpressure and occasional reset.
    for (int s = 0; s < 150; s++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 7);
      if (kind < 6)       rseg = glyphs[$urandom_range(0, 15)];
      else if (kind == 6) rseg = 7'h00;
      else                rseg = 7'($urandom);
      if (kind == 9) step("rnd_rst", rseg, 1'b1, 1'b1);
      for (int i = 0; i < hold; i++) step("rnd", rseg, ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
